// File: rtl/snoop_cache_2way_if.sv
// CPU and snoop port bundle for the 2-way snooping line cache.
interface snoop_cache_2way_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned LINE_W = 64
);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [LINE_W-1:0] wr_data;
    logic              wdirty;
    logic [LINE_W-1:0] rd_data;
    logic              hit;
    logic              dirty;
    logic [TAG_W-1:0]  tag_out;

    logic              snp_req;
    logic [ADDR_W-1:0] snp_addr;
    logic              snp_inv;
    logic              snp_valid;
    logic              snp_found;
    logic              snp_dirty;
    logic [LINE_W-1:0] snp_data;

    modport master (
        output addr, re, we, wr_data, wdirty, snp_req, snp_addr, snp_inv,
        input  rd_data, hit, dirty, tag_out, snp_valid, snp_found, snp_dirty, snp_data
    );

    modport slave (
        input  addr, re, we, wr_data, wdirty, snp_req, snp_addr, snp_inv,
        output rd_data, hit, dirty, tag_out, snp_valid, snp_found, snp_dirty, snp_data
    );
endinterface

// File: rtl/snoop_cache_2way.sv
// 2-way set-associative write-allocate line cache, true LRU, with a snoop port.
module snoop_cache_2way #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned LINE_W = 64
) (
    input logic               clk,
    input logic               rst_n,
    snoop_cache_2way_if.slave bus
);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned SETS  = 2 ** IDX_W;

    logic [LINE_W-1:0] data_a  [2][SETS];
    logic [TAG_W-1:0]  tag_a   [2][SETS];
    logic [SETS-1:0]   valid_a [2];
    logic [SETS-1:0]   dirty_a [2];
    logic [SETS-1:0]   lru;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] s_idx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] s_tag;
    logic [1:0]       match;
    logic [1:0]       s_match;
    logic             hit_c;
    logic             hit_way;
    logic             victim;
    logic             tgt_way;
    logic             s_found;
    logic             s_way;

    assign idx   = bus.addr[IDX_W-1:0];
    assign tag   = bus.addr[ADDR_W-1:IDX_W];
    assign s_idx = bus.snp_addr[IDX_W-1:0];
    assign s_tag = bus.snp_addr[ADDR_W-1:IDX_W];

    // Tag compare for both ports, victim selection and CPU write target.
    always_comb begin
        match   = 2'b00;
        s_match = 2'b00;
        for (int w = 0; w < 2; w++) begin
            match[w]   = valid_a[w][idx]   && (tag_a[w][idx]   == tag);
            s_match[w] = valid_a[w][s_idx] && (tag_a[w][s_idx] == s_tag);
        end
        hit_c   = |match;
        hit_way = ~match[0];
        if (!valid_a[0][idx]) begin
            victim = 1'b0;
        end else if (!valid_a[1][idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru[idx];
        end
        tgt_way = hit_c ? hit_way : victim;
        s_found = |s_match;
        s_way   = ~s_match[0];
    end

    // Line data and tag storage; not reset, validity lives in valid_a.
    always_ff @(posedge clk) begin
        if (bus.we) begin
            data_a[tgt_way][idx] <= bus.wr_data;
            tag_a[tgt_way][idx]  <= tag;
        end
    end

    // Valid/dirty/LRU state plus registered CPU and snoop responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_a[0]    <= '0;
            valid_a[1]    <= '0;
            dirty_a[0]    <= '0;
            dirty_a[1]    <= '0;
            lru           <= '0;
            bus.rd_data   <= '0;
            bus.hit       <= 1'b0;
            bus.dirty     <= 1'b0;
            bus.tag_out   <= '0;
            bus.snp_valid <= 1'b0;
            bus.snp_found <= 1'b0;
            bus.snp_dirty <= 1'b0;
            bus.snp_data  <= '0;
        end else begin
            bus.snp_valid <= 1'b0;
            if (bus.we) begin
                valid_a[tgt_way][idx] <= 1'b1;
                dirty_a[tgt_way][idx] <= bus.wdirty;
                lru[idx]              <= ~tgt_way;
            end else if (bus.re) begin
                bus.hit <= hit_c;
                if (hit_c) begin
                    bus.rd_data <= data_a[hit_way][idx];
                    bus.tag_out <= tag;
                    bus.dirty   <= 1'b0;
                    lru[idx]    <= ~hit_way;
                end else begin
                    bus.rd_data <= data_a[victim][idx];
                    bus.tag_out <= tag_a[victim][idx];
                    bus.dirty   <= valid_a[victim][idx] && dirty_a[victim][idx];
                end
            end
            // Snoop sees pre-edge contents; its invalidate is issued last so it overrides a same-way write.
            if (bus.snp_req) begin
                bus.snp_valid <= 1'b1;
                bus.snp_found <= s_found;
                bus.snp_dirty <= s_found && dirty_a[s_way][s_idx];
                bus.snp_data  <= s_found ? data_a[s_way][s_idx] : '0;
                if (bus.snp_inv && s_found) begin
                    valid_a[s_way][s_idx] <= 1'b0;
                    dirty_a[s_way][s_idx] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_snoop_cache_2way.sv
// Self-checking bench: directed vector table, randomized run against a set/way model, small-geometry sweep.
module tb_snoop_cache_2way;
    localparam int SETS1 = 64;

    logic clk;
    logic rst_n;
    logic rst2_n;

    int checks = 0;
    int errors = 0;

    snoop_cache_2way_if #(.ADDR_W(11), .IDX_W(6), .LINE_W(64)) bus ();
    snoop_cache_2way_if #(.ADDR_W(9), .IDX_W(4), .LINE_W(128)) bus2 ();

    snoop_cache_2way #(.ADDR_W(11), .IDX_W(6), .LINE_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    snoop_cache_2way #(.ADDR_W(9), .IDX_W(4), .LINE_W(128)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of the main cache: per-set, per-way records.
    bit          m_v   [SETS1][2];
    bit          m_d   [SETS1][2];
    bit          m_k   [SETS1][2];
    int          m_t   [SETS1][2];
    logic [63:0] m_dat [SETS1][2];
    int          m_lru [SETS1];
    bit          e_hit, e_dirty, e_rdk, e_sv, e_sf, e_sd;
    logic [4:0]  e_tag;
    logic [63:0] e_rd, e_sdat;

    task automatic model_reset();
        for (int s = 0; s < SETS1; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_v[s][w] = 0;
                m_d[s][w] = 0;
                m_k[s][w] = 0;
            end
        end
        e_hit = 0; e_dirty = 0; e_rdk = 1; e_tag = '0; e_rd = '0;
        e_sv = 0; e_sf = 0; e_sd = 0; e_sdat = '0;
    endtask

    task automatic model_step(input bit re, input bit we, input logic [10:0] addr,
                              input logic [63:0] wd, input bit wdirty, input bit sreq,
                              input logic [10:0] saddr, input bit sinv);
        int s, t, ss, st, hw, sw, vic, tw;
        s  = int'(addr) % SETS1;
        t  = int'(addr) / SETS1;
        ss = int'(saddr) % SETS1;
        st = int'(saddr) / SETS1;
        hw = -1; sw = -1; tw = -1;
        for (int w = 0; w < 2; w++) begin
            if (m_v[s][w] && m_t[s][w] == t) hw = w;
            if (m_v[ss][w] && m_t[ss][w] == st) sw = w;
        end
        vic = !m_v[s][0] ? 0 : (!m_v[s][1] ? 1 : m_lru[s]);
        e_sv = 0;
        if (sreq) begin
            e_sv   = 1;
            e_sf   = (sw >= 0);
            e_sd   = (sw >= 0) ? m_d[ss][sw] : 1'b0;
            e_sdat = (sw >= 0) ? m_dat[ss][sw] : 64'd0;
        end
        if (we) begin
            tw = (hw >= 0) ? hw : vic;
            m_v[s][tw] = 1; m_d[s][tw] = wdirty; m_t[s][tw] = t;
            m_dat[s][tw] = wd; m_k[s][tw] = 1;
            m_lru[s] = 1 - tw;
        end else if (re) begin
            if (hw >= 0) begin
                e_hit = 1; e_rd = m_dat[s][hw]; e_tag = 5'(t); e_dirty = 0; e_rdk = 1;
                m_lru[s] = 1 - hw;
            end else begin
                e_hit = 0; e_rd = m_dat[s][vic]; e_tag = 5'(m_t[s][vic]);
                e_rdk = m_k[s][vic]; e_dirty = m_v[s][vic] && m_d[s][vic];
            end
        end
        if (sreq && sinv && sw >= 0) begin
            if (we && tw == sw && s == ss) m_k[ss][sw] = 0;
            m_v[ss][sw] = 0;
            m_d[ss][sw] = 0;
        end
    endtask

    task automatic cycle(input bit re, input bit we, input logic [10:0] addr,
                         input logic [63:0] wd, input bit wdirty, input bit sreq,
                         input logic [10:0] saddr, input bit sinv);
        bus.re = re; bus.we = we; bus.addr = addr; bus.wr_data = wd; bus.wdirty = wdirty;
        bus.snp_req = sreq; bus.snp_addr = saddr; bus.snp_inv = sinv;
        @(posedge clk);
        model_step(re, we, addr, wd, wdirty, sreq, saddr, sinv);
        #1;
    endtask

    task automatic cycle2(input bit re, input bit we, input logic [8:0] addr, input logic [127:0] wd);
        bus2.re = re; bus2.we = we; bus2.addr = addr; bus2.wr_data = wd; bus2.wdirty = 1'b0;
        bus2.snp_req = 1'b0; bus2.snp_addr = '0; bus2.snp_inv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit re; bit we; logic [10:0] addr; logic [63:0] wd; bit wdirty;
        bit sreq; logic [10:0] saddr; bit sinv;
        bit e_hit; bit e_dirty; bit chk_rd; logic [4:0] e_tag; logic [63:0] e_rd;
        bit e_sv; bit e_sf; bit e_sd; logic [63:0] e_sdat;
    } vec_t;

    localparam logic [63:0] LA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] LB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] LC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] LD = 64'hDDDD_DDDD_DDDD_DDDD;

    vec_t         vecs[$];
    logic [127:0] lines2 [16][2];
    logic [8:0]   addrs2 [16][2];

    initial begin
        vec_t v;
        // re, we, addr, wd, wdirty, sreq, saddr, sinv, hit, dirty, chk_rd, tag, rd, sv, sf, sd, sdat
        vecs.push_back('{1, 0, 11'h045, 64'd0, 0, 0, 11'h000, 0, 0, 0, 0, 5'd0, 64'd0, 0, 0, 0, 64'd0});
        vecs.push_back('{0, 0, 11'h000, 64'd0, 0, 1, 11'h045, 0, 0, 0, 0, 5'd0, 64'd0, 1, 0, 0, 64'd0});
        vecs.push_back('{0, 1, 11'h045, LA,    0, 0, 11'h000, 0, 0, 0, 0, 5'd0, 64'd0, 0, 0, 0, 64'd0});
        vecs.push_back('{0, 1, 11'h085, LB,    0, 0, 11'h000, 0, 0, 0, 0, 5'd0, 64'd0, 0, 0, 0, 64'd0});
        vecs.push_back('{1, 0, 11'h045, 64'd0, 0, 0, 11'h000, 0, 1, 0, 1, 5'd1, LA,    0, 0, 0, 64'd0});
        vecs.push_back('{1, 0, 11'h0C5, 64'd0, 0, 0, 11'h000, 0, 0, 0, 1, 5'd2, LB,    0, 0, 0, 64'd0});
        vecs.push_back('{0, 1, 11'h0C5, LC,    1, 0, 11'h000, 0, 0, 0, 1, 5'd2, LB,    0, 0, 0, 64'd0});
        vecs.push_back('{1, 0, 11'h085, 64'd0, 0, 0, 11'h000, 0, 0, 0, 1, 5'd1, LA,    0, 0, 0, 64'd0});
        vecs.push_back('{1, 0, 11'h045, 64'd0, 0, 0, 11'h000, 0, 1, 0, 1, 5'd1, LA,    0, 0, 0, 64'd0});
        vecs.push_back('{1, 0, 11'h105, 64'd0, 0, 0, 11'h000, 0, 0, 1, 1, 5'd3, LC,    0, 0, 0, 64'd0});
        vecs.push_back('{0, 0, 11'h000, 64'd0, 0, 1, 11'h0C5, 1, 0, 1, 1, 5'd3, LC,    1, 1, 1, LC});
        vecs.push_back('{1, 0, 11'h0C5, 64'd0, 0, 0, 11'h000, 0, 0, 0, 1, 5'd3, LC,    0, 1, 1, LC});
        vecs.push_back('{1, 0, 11'h045, 64'd0, 0, 0, 11'h000, 0, 1, 0, 1, 5'd1, LA,    0, 1, 1, LC});
        vecs.push_back('{0, 1, 11'h045, LD,    0, 1, 11'h045, 1, 1, 0, 1, 5'd1, LA,    1, 1, 0, LA});
        vecs.push_back('{1, 0, 11'h045, 64'd0, 0, 0, 11'h000, 0, 0, 0, 0, 5'd0, 64'd0, 0, 1, 0, LA});

        rst_n = 1'b0; rst2_n = 1'b0;
        bus.re = 0; bus.we = 0; bus.addr = '0; bus.wr_data = '0; bus.wdirty = 0;
        bus.snp_req = 0; bus.snp_addr = '0; bus.snp_inv = 0;
        bus2.re = 0; bus2.we = 0; bus2.addr = '0; bus2.wr_data = '0; bus2.wdirty = 0;
        bus2.snp_req = 0; bus2.snp_addr = '0; bus2.snp_inv = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset state: every output reads zero.
        chk("rst_hit", 128'(bus.hit), 128'(0));
        chk("rst_dirty", 128'(bus.dirty), 128'(0));
        chk("rst_rd_data", 128'(bus.rd_data), 128'(0));
        chk("rst_tag_out", 128'(bus.tag_out), 128'(0));
        chk("rst_snp_valid", 128'(bus.snp_valid), 128'(0));
        chk("rst_snp_found", 128'(bus.snp_found), 128'(0));
        chk("rst_snp_data", 128'(bus.snp_data), 128'(0));
        rst_n = 1'b1; rst2_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.re, v.we, v.addr, v.wd, v.wdirty, v.sreq, v.saddr, v.sinv);
            chk($sformatf("vec%0d_hit", i), 128'(bus.hit), 128'(v.e_hit));
            chk($sformatf("vec%0d_dirty", i), 128'(bus.dirty), 128'(v.e_dirty));
            if (v.chk_rd) begin
                chk($sformatf("vec%0d_rd_data", i), 128'(bus.rd_data), 128'(v.e_rd));
                chk($sformatf("vec%0d_tag_out", i), 128'(bus.tag_out), 128'(v.e_tag));
            end
            chk($sformatf("vec%0d_snp_valid", i), 128'(bus.snp_valid), 128'(v.e_sv));
            chk($sformatf("vec%0d_snp_found", i), 128'(bus.snp_found), 128'(v.e_sf));
            chk($sformatf("vec%0d_snp_dirty", i), 128'(bus.snp_dirty), 128'(v.e_sd));
            chk($sformatf("vec%0d_snp_data", i), 128'(bus.snp_data), 128'(v.e_sdat));
        end

        // Randomized traffic over a few sets and tags so hits, evictions and collisions occur.
        for (int i = 0; i < 600; i++) begin
            logic [10:0] a, sa;
            logic [63:0] d;
            a  = 11'(($urandom_range(0, 3) * SETS1) + $urandom_range(0, 3));
            sa = 11'(($urandom_range(0, 3) * SETS1) + $urandom_range(0, 3));
            d  = {$urandom, $urandom};
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, a, d,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, sa,
                  $urandom_range(0, 1) == 1);
            chk("rnd_hit", 128'(bus.hit), 128'(e_hit));
            chk("rnd_dirty", 128'(bus.dirty), 128'(e_dirty));
            if (e_rdk) begin
                chk("rnd_rd_data", 128'(bus.rd_data), 128'(e_rd));
                chk("rnd_tag_out", 128'(bus.tag_out), 128'(e_tag));
            end
            chk("rnd_snp_valid", 128'(bus.snp_valid), 128'(e_sv));
            chk("rnd_snp_found", 128'(bus.snp_found), 128'(e_sf));
            chk("rnd_snp_dirty", 128'(bus.snp_dirty), 128'(e_sd));
            chk("rnd_snp_data", 128'(bus.snp_data), 128'(e_sdat));
        end
        cycle(0, 0, '0, '0, 0, 0, '0, 0);

        // Small geometry: fill every set and way, read everything back.
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                addrs2[s][w] = 9'(((w * 7 + (s % 3) + 1) * 16) + s);
                lines2[s][w] = {$urandom, $urandom, $urandom, $urandom};
                cycle2(0, 1, addrs2[s][w], lines2[s][w]);
            end
        end
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                cycle2(1, 0, addrs2[s][w], '0);
                chk($sformatf("sweep_hit_s%0d_w%0d", s, w), 128'(bus2.hit), 128'(1));
                chk($sformatf("sweep_rd_s%0d_w%0d", s, w), bus2.rd_data, lines2[s][w]);
                chk($sformatf("sweep_tag_s%0d_w%0d", s, w), 128'(bus2.tag_out),
                    128'(addrs2[s][w] >> 4));
            end
        end

        // Reset in the middle of a read stream clears everything at once.
        cycle2(1, 0, addrs2[3][0], '0);
        chk("midrst_pre_hit", 128'(bus2.hit), 128'(1));
        bus2.addr = addrs2[4][1];
        rst2_n = 1'b0;
        #1;
        chk("midrst_hit", 128'(bus2.hit), 128'(0));
        chk("midrst_rd_data", bus2.rd_data, 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                cycle2(1, 0, addrs2[s][w], '0);
                chk($sformatf("cold_hit_s%0d_w%0d", s, w), 128'(bus2.hit), 128'(0));
                chk($sformatf("cold_dirty_s%0d_w%0d", s, w), 128'(bus2.dirty), 128'(0));
            end
        end
        cycle2(0, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
